mdr_mem_port: RTL and testbench

Parametrised memory data register with a self-timed memory handshake. It is the next-generation MDR for the datapath. Like the current MDR, it loads from the bus or from memory and drives its contents onto the bus. It adds its own req/ack memory transactions, byte/halfword/word sizing with lane alignment, sign or zero extension on loads, and a timeout error flag. It sits between the bus multiplexer, the control unit and the memory interface.

---
 rtl/mdr_pkg.sv | 29 ++
 rtl/mdr_lane_align.sv | 64 ++++++
 rtl/mdr_mem_port.sv | 224 ++++++++++++++++++++++
 tb/tb_mdr_mem_port.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mdr_pkg.sv
// Shared definitions for the memory data register: size codes, FSM states
// and the access alignment rule.
package mdr_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_FULL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RD_WAIT = 2'b01,
        ST_WR_WAIT = 2'b10
    } mdr_state_t;

    // Offset is passed zero-extended to 8 bits so one function serves every DATA_W.
    function automatic logic is_aligned(input logic [1:0] sz, input logic [7:0] off);
        logic ok;
        case (sz)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = (off[0] == 1'b0);
            SZ_WORD: ok = (off[1:0] == 2'b00);
            SZ_FULL: ok = (off == 8'h00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mdr_lane_align.sv
// Combinational byte-lane steering: lane enables, write data placement and
// read field extraction with sign/zero extension.
module mdr_lane_align
    import mdr_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [1:0]                    size,
    input  logic                          signed_ld,
    input  logic [$clog2(DATA_W/8)-1:0]   off,
    input  logic [DATA_W-1:0]             wr_src,
    input  logic [DATA_W-1:0]             rd_src,
    output logic [DATA_W/8-1:0]           be,
    output logic [DATA_W-1:0]             wdata,
    output logic [DATA_W-1:0]             rdata
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);

    logic [NB-1:0]     lane_mask_s;
    logic [DATA_W-1:0] field_mask_s;
    logic [DATA_W-1:0] rd_shift_s;
    logic [OFF_W+2:0]  sh_s;
    logic              sign_s;

    assign sh_s = {off, 3'b000};

    // Lane and bit masks for the access size, anchored at lane 0.
    always_comb begin
        lane_mask_s  = '0;
        field_mask_s = '0;
        case (size)
            SZ_BYTE: lane_mask_s[0]   = 1'b1;
            SZ_HALF: lane_mask_s[1:0] = 2'b11;
            SZ_WORD: lane_mask_s[3:0] = 4'b1111;
            SZ_FULL: lane_mask_s      = '1;
            default: lane_mask_s      = '0;
        endcase
        for (int i = 0; i < NB; i++) begin
            field_mask_s[8*i +: 8] = {8{lane_mask_s[i]}};
        end
    end

    // Place the write field into its lanes and pull the read field down to bit 0.
    always_comb begin
        be         = lane_mask_s << off;
        wdata      = (wr_src & field_mask_s) << sh_s;
        rd_shift_s = rd_src >> sh_s;
        case (size)
            SZ_BYTE: sign_s = rd_shift_s[7];
            SZ_HALF: sign_s = rd_shift_s[15];
            SZ_WORD: sign_s = rd_shift_s[31];
            SZ_FULL: sign_s = rd_shift_s[DATA_W-1];
            default: sign_s = 1'b0;
        endcase
        if (signed_ld && sign_s) begin
            rdata = (rd_shift_s & field_mask_s) | ~field_mask_s;
        end else begin
            rdata = rd_shift_s & field_mask_s;
        end
    end

endmodule

// File: rtl/mdr_mem_port.sv
// Memory data register with its own req/ack memory transactions, sized
// lane-aligned accesses, load extension and a sticky error flag.
module mdr_mem_port
    import mdr_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                          clk,
    input  logic                          clr,
    input  logic [DATA_W-1:0]             bus_mux_out,
    input  logic                          mdr_in,
    input  logic                          mdr_read,
    input  logic                          mdr_write,
    input  logic [1:0]                    size,
    input  logic                          signed_ld,
    input  logic [$clog2(DATA_W/8)-1:0]   byte_off,
    input  logic [DATA_W-1:0]             mem_rdata,
    input  logic                          mem_ack,
    output logic [DATA_W-1:0]             q,
    output logic                          mem_req,
    output logic                          mem_we,
    output logic [DATA_W/8-1:0]           mem_be,
    output logic [DATA_W-1:0]             mem_wdata,
    output logic                          busy,
    output logic                          err
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    // Counter value seen on the last wait edge before the timeout fires.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    mdr_state_t        state_r, state_nxt_s;
    logic [DATA_W-1:0] q_r, q_nxt_s;
    logic              req_r, req_nxt_s;
    logic              we_r, we_nxt_s;
    logic [NB-1:0]     be_r, be_nxt_s;
    logic [DATA_W-1:0] wdata_r, wdata_nxt_s;
    logic              busy_r, busy_nxt_s;
    logic              err_r, err_nxt_s;
    logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
    logic [1:0]        lat_size_r, lat_size_nxt_s;
    logic              lat_signed_r, lat_signed_nxt_s;
    logic [OFF_W-1:0]  lat_off_r, lat_off_nxt_s;

    logic              aligned_s;
    logic              timeout_s;
    logic [1:0]        al_size_s;
    logic              al_signed_s;
    logic [OFF_W-1:0]  al_off_s;
    logic [NB-1:0]     be_s;
    logic [DATA_W-1:0] wdata_s;
    logic [DATA_W-1:0] rdata_s;

    assign aligned_s = is_aligned(size, 8'(byte_off));

    // Steering uses the live command in IDLE and the latched access while waiting.
    always_comb begin
        if (state_r == ST_IDLE) begin
            al_size_s   = size;
            al_signed_s = signed_ld;
            al_off_s    = byte_off;
        end else begin
            al_size_s   = lat_size_r;
            al_signed_s = lat_signed_r;
            al_off_s    = lat_off_r;
        end
    end

    mdr_lane_align #(.DATA_W(DATA_W)) u_align (
        .size      (al_size_s),
        .signed_ld (al_signed_s),
        .off       (al_off_s),
        .wr_src    (q_r),
        .rd_src    (mem_rdata),
        .be        (be_s),
        .wdata     (wdata_s),
        .rdata     (rdata_s)
    );

    // Timeout fires when the last allowed wait cycle passes without an ack.
    always_comb begin
        if ((TIMEOUT != 0) && (cnt_r == TO_LAST) && !mem_ack) begin
            timeout_s = 1'b1;
        end else begin
            timeout_s = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!clr) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (mdr_read && aligned_s) begin
                    state_nxt_s = ST_RD_WAIT;
                end else if (mdr_write && !mdr_read && aligned_s) begin
                    state_nxt_s = ST_WR_WAIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RD_WAIT, ST_WR_WAIT: begin
                if (mem_ack || timeout_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Next values for the data, handshake and error registers.
    always_comb begin
        q_nxt_s          = q_r;
        req_nxt_s        = req_r;
        we_nxt_s         = we_r;
        be_nxt_s         = be_r;
        wdata_nxt_s      = wdata_r;
        err_nxt_s        = err_r;
        cnt_nxt_s        = cnt_r;
        lat_size_nxt_s   = lat_size_r;
        lat_signed_nxt_s = lat_signed_r;
        lat_off_nxt_s    = lat_off_r;
        busy_nxt_s       = (state_nxt_s != ST_IDLE);
        case (state_r)
            ST_IDLE: begin
                if (mdr_read || mdr_write) begin
                    if (aligned_s) begin
                        err_nxt_s        = 1'b0;
                        req_nxt_s        = 1'b1;
                        we_nxt_s         = !mdr_read;
                        be_nxt_s         = be_s;
                        wdata_nxt_s      = wdata_s;
                        cnt_nxt_s        = '0;
                        lat_size_nxt_s   = size;
                        lat_signed_nxt_s = signed_ld;
                        lat_off_nxt_s    = byte_off;
                    end else begin
                        err_nxt_s = 1'b1;
                    end
                end else if (mdr_in) begin
                    q_nxt_s = bus_mux_out;
                end else begin
                    q_nxt_s = q_r;
                end
            end
            ST_RD_WAIT, ST_WR_WAIT: begin
                if (mem_ack || timeout_s) begin
                    req_nxt_s = 1'b0;
                    we_nxt_s  = 1'b0;
                    be_nxt_s  = '0;
                    if (mem_ack && (state_r == ST_RD_WAIT)) begin
                        q_nxt_s = rdata_s;
                    end else begin
                        q_nxt_s = q_r;
                    end
                    if (!mem_ack) begin
                        err_nxt_s = 1'b1;
                    end else begin
                        err_nxt_s = err_r;
                    end
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                req_nxt_s = 1'b0;
                we_nxt_s  = 1'b0;
                be_nxt_s  = '0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (!clr) begin
            q_r          <= '0;
            req_r        <= 1'b0;
            we_r         <= 1'b0;
            be_r         <= '0;
            wdata_r      <= '0;
            busy_r       <= 1'b0;
            err_r        <= 1'b0;
            cnt_r        <= '0;
            lat_size_r   <= SZ_BYTE;
            lat_signed_r <= 1'b0;
            lat_off_r    <= '0;
        end else begin
            q_r          <= q_nxt_s;
            req_r        <= req_nxt_s;
            we_r         <= we_nxt_s;
            be_r         <= be_nxt_s;
            wdata_r      <= wdata_nxt_s;
            busy_r       <= busy_nxt_s;
            err_r        <= err_nxt_s;
            cnt_r        <= cnt_nxt_s;
            lat_size_r   <= lat_size_nxt_s;
            lat_signed_r <= lat_signed_nxt_s;
            lat_off_r    <= lat_off_nxt_s;
        end
    end

    assign q         = q_r;
    assign mem_req   = req_r;
    assign mem_we    = we_r;
    assign mem_be    = be_r;
    assign mem_wdata = wdata_r;
    assign busy      = busy_r;
    assign err       = err_r;

endmodule

// File: tb/tb_mdr_mem_port.sv
// Directed self-checking bench for mdr_mem_port (DATA_W=32, TIMEOUT=4).
module tb_mdr_mem_port;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] bus_mux_out;
    logic        mdr_in;
    logic        mdr_read;
    logic        mdr_write;
    logic [1:0]  size;
    logic        signed_ld;
    logic [1:0]  byte_off;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [31:0] q;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        err;

    int total = 0;
    int bad   = 0;

    mdr_mem_port #(.DATA_W(32), .TIMEOUT(4)) dut (
        .clk         (clk),
        .clr         (clr),
        .bus_mux_out (bus_mux_out),
        .mdr_in      (mdr_in),
        .mdr_read    (mdr_read),
        .mdr_write   (mdr_write),
        .size        (size),
        .signed_ld   (signed_ld),
        .byte_off    (byte_off),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .q           (q),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_be      (mem_be),
        .mem_wdata   (mem_wdata),
        .busy        (busy),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue a read/write command for one edge, then drop it.
    task automatic cmd(input logic rd, input logic wr, input logic [1:0] sz,
                       input logic [1:0] off, input logic sgn);
        mdr_read  = rd;
        mdr_write = wr;
        size      = sz;
        byte_off  = off;
        signed_ld = sgn;
        step();
        mdr_read  = 1'b0;
        mdr_write = 1'b0;
    endtask

    task automatic ack();
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
    endtask

    initial begin
        clr = 1'b0; bus_mux_out = 32'h0; mdr_in = 1'b0; mdr_read = 1'b0;
        mdr_write = 1'b0; size = 2'b00; signed_ld = 1'b0; byte_off = 2'b00;
        mem_rdata = 32'h0; mem_ack = 1'b0;
        step();
        step();
        chk("rst_q", q, 32'h0);
        chk("rst_req", {31'h0, mem_req}, 32'h0);
        chk("rst_we", {31'h0, mem_we}, 32'h0);
        chk("rst_be", {28'h0, mem_be}, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);
        clr = 1'b1;

        // reset in the middle of a read
        cmd(1'b1, 1'b0, 2'b10, 2'd0, 1'b0);
        chk("mid_req_up", {31'h0, mem_req}, 32'h1);
        chk("mid_busy_up", {31'h0, busy}, 32'h1);
        clr = 1'b0;
        step();
        clr = 1'b1;
        chk("mid_req", {31'h0, mem_req}, 32'h0);
        chk("mid_busy", {31'h0, busy}, 32'h0);
        chk("mid_err", {31'h0, err}, 32'h0);
        chk("mid_q", q, 32'h0);

        // bus load, then byte write to lane 2
        bus_mux_out = 32'hDEADBEEF;
        mdr_in = 1'b1;
        step();
        mdr_in = 1'b0;
        chk("load_q", q, 32'hDEADBEEF);
        cmd(1'b0, 1'b1, 2'b00, 2'd2, 1'b0);
        chk("wr_be", {28'h0, mem_be}, 32'h4);
        chk("wr_wdata", mem_wdata, 32'h00EF0000);
        chk("wr_we", {31'h0, mem_we}, 32'h1);
        chk("wr_busy", {31'h0, busy}, 32'h1);
        step();
        step();
        chk("wr_req_hold", {31'h0, mem_req}, 32'h1);
        chk("wr_wdata_hold", mem_wdata, 32'h00EF0000);
        ack();
        chk("wr_done_busy", {31'h0, busy}, 32'h0);
        chk("wr_done_req", {31'h0, mem_req}, 32'h0);
        chk("wr_done_we", {31'h0, mem_we}, 32'h0);
        chk("wr_done_q", q, 32'hDEADBEEF);

        // signed byte load from lane 3; live inputs change while waiting
        mem_rdata = 32'h80123456;
        cmd(1'b1, 1'b0, 2'b00, 2'd3, 1'b1);
        signed_ld = 1'b0; size = 2'b10; byte_off = 2'd0;
        chk("rdb_be", {28'h0, mem_be}, 32'h8);
        chk("rdb_we", {31'h0, mem_we}, 32'h0);
        ack();
        chk("rdb_signed_q", q, 32'hFFFFFF80);
        chk("rdb_busy", {31'h0, busy}, 32'h0);
        chk("rdb_be_drop", {28'h0, mem_be}, 32'h0);
        cmd(1'b1, 1'b0, 2'b00, 2'd3, 1'b0);
        ack();
        chk("rdb_unsigned_q", q, 32'h00000080);

        // halfword loads, then misaligned half
        mem_rdata = 32'hBEEF1234;
        cmd(1'b1, 1'b0, 2'b01, 2'd2, 1'b0);
        chk("rdh_be", {28'h0, mem_be}, 32'hC);
        ack();
        chk("rdh_unsigned_q", q, 32'h0000BEEF);
        cmd(1'b1, 1'b0, 2'b01, 2'd2, 1'b1);
        ack();
        chk("rdh_signed_q", q, 32'hFFFFBEEF);
        cmd(1'b1, 1'b0, 2'b01, 2'd1, 1'b0);
        chk("mis_err", {31'h0, err}, 32'h1);
        chk("mis_req", {31'h0, mem_req}, 32'h0);
        chk("mis_busy", {31'h0, busy}, 32'h0);
        chk("mis_q", q, 32'hFFFFBEEF);
        step();
        chk("mis_req_later", {31'h0, mem_req}, 32'h0);
        cmd(1'b0, 1'b1, 2'b10, 2'd2, 1'b0);
        chk("mis_word_err", {31'h0, err}, 32'h1);
        chk("mis_word_req", {31'h0, mem_req}, 32'h0);

        // full-width read clears err on acceptance
        mem_rdata = 32'h12345678;
        cmd(1'b1, 1'b0, 2'b11, 2'd0, 1'b1);
        chk("full_err_clr", {31'h0, err}, 32'h0);
        chk("full_be", {28'h0, mem_be}, 32'hF);
        ack();
        chk("full_q", q, 32'h12345678);

        // timeout with TIMEOUT=4: err and idle from the 5th cycle after acceptance
        cmd(1'b1, 1'b0, 2'b10, 2'd0, 1'b0);
        chk("to_busy_start", {31'h0, busy}, 32'h1);
        step();
        step();
        step();
        chk("to_busy_c4", {31'h0, busy}, 32'h1);
        chk("to_req_c4", {31'h0, mem_req}, 32'h1);
        chk("to_err_c4", {31'h0, err}, 32'h0);
        step();
        chk("to_err", {31'h0, err}, 32'h1);
        chk("to_busy", {31'h0, busy}, 32'h0);
        chk("to_req", {31'h0, mem_req}, 32'h0);
        chk("to_q", q, 32'h12345678);

        // ack while idle is ignored
        mem_rdata = 32'hAAAA5555;
        ack();
        chk("idle_ack_q", q, 32'h12345678);
        chk("idle_ack_busy", {31'h0, busy}, 32'h0);

        // aligned read with immediate ack recovers err
        mem_rdata = 32'hCAFEF00D;
        cmd(1'b1, 1'b0, 2'b10, 2'd0, 1'b0);
        chk("rec_err", {31'h0, err}, 32'h0);
        ack();
        chk("rec_q", q, 32'hCAFEF00D);

        // mdr_in together with mdr_read, and mdr_in while waiting
        bus_mux_out = 32'h11111111;
        mem_rdata   = 32'h22222222;
        mdr_in = 1'b1;
        cmd(1'b1, 1'b0, 2'b10, 2'd0, 1'b0);
        bus_mux_out = 32'h33333333;
        chk("sim_busy", {31'h0, busy}, 32'h1);
        chk("sim_q", q, 32'hCAFEF00D);
        step();
        chk("wait_in_q", q, 32'hCAFEF00D);
        mdr_in = 1'b0;
        ack();
        chk("sim_read_q", q, 32'h22222222);
        step();
        chk("no_queue_q", q, 32'h22222222);

        // read beats write; then word and half writes of q
        cmd(1'b1, 1'b1, 2'b10, 2'd0, 1'b0);
        chk("prio_we", {31'h0, mem_we}, 32'h0);
        ack();
        cmd(1'b0, 1'b1, 2'b10, 2'd0, 1'b0);
        chk("ww_be", {28'h0, mem_be}, 32'hF);
        chk("ww_wdata", mem_wdata, 32'h22222222);
        ack();
        cmd(1'b0, 1'b1, 2'b01, 2'd2, 1'b0);
        chk("hw_be", {28'h0, mem_be}, 32'hC);
        chk("hw_wdata", mem_wdata, 32'h22220000);
        ack();
        chk("hw_done_busy", {31'h0, busy}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
